echo_request_arbiter: RTL
=========================

ECHO_REQUEST_ARBITER -- requirements
Module: echo_request_arbiter

Interface
REQ-001 Parameter CNT_W, default 16, width of the per-requester grant counters.
REQ-002 Parameter RR, default 1; 1 = round-robin arbitration, 0 = fixed priority with say over say2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 request$say__ENA  input  1  say method invoke; asserted only while request$say__RDY is high.
REQ-006 request$say$meth  input  32  say method field.
REQ-007 request$say$v  input  32  say value field.
REQ-008 request$say__RDY  output  1  say holding slot can accept this cycle.
REQ-009 request$say2__ENA  input  1  say2 method invoke; asserted only while request$say2__RDY is high.
REQ-010 request$say2$meth, request$say2$v, request$say2$v2  input  32 each  say2 fields.
REQ-011 request$say2__RDY  output  1  say2 holding slot can accept this cycle.
REQ-012 pipe$enq__ENA  output  1  message transfer to downstream pipe.
REQ-013 pipe$enq$v  output  192  message; valid only while pipe$enq__ENA is high, else all zero.
REQ-014 pipe$enq__RDY  input  1  downstream pipe can accept.
REQ-015 sayCount, say2Count  output  CNT_W each  number of messages forwarded per requester.

Function
REQ-016 Each requester owns a one-entry holding register (valid bit plus fields); capture on ENA, cycle n; earliest forward cycle n+1; no same-cycle bypass.
REQ-017 Message layout: [31:0] tag (32'd1 say, 32'd2 say2); [63:32] say.meth; [95:64] say.v; [127:96] say2.meth; [159:128] say2.v; [191:160] say2.v2; fields of the other method are zero.
REQ-018 pipe$enq__ENA = (say valid | say2 valid) & pipe$enq__RDY; never asserted while pipe$enq__RDY is low.
REQ-019 Exactly one requester granted per transfer; the granted holding register is cleared at the clock edge of the transfer.
REQ-020 RR=1: only one valid -> grant it; both valid -> grant the requester not granted last; last-grant pointer updates only on a transfer.
REQ-021 RR=0: both valid -> grant say; say2 may starve, by design.
REQ-022 request$X__RDY = !validX | (grantX & pipe$enq__RDY); capture and drain in the same cycle leaves validX = 1 holding the new message.
REQ-023 pipe$enq__RDY low: both holding registers keep contents, RDY of full slots low, no pointer or counter change.
REQ-024 Counter of the granted requester increments by 1 per transfer, wrapping modulo 2^CNT_W without flag.
REQ-025 Both requesters may be invoked in the same cycle; both captured independently.

Reset
REQ-026 While RST is high at a clock edge: both valid bits 0, last-grant pointer = say2 (so say wins the first tie), counters 0.
REQ-027 Outputs during and after reset: pipe$enq__ENA 0, pipe$enq$v 0, both RDY 1; held messages are discarded without transfer.
REQ-028 ENA inputs while RST is high are ignored.

Structure
REQ-029 Shared package holds tag constants (SAY_TAG=1, SAY2_TAG=2), message width 192 and field offsets, used also by the message decoder.
REQ-030 One sub-module, echo_hold_slot (one-entry register with valid, load, clear, combinational RDY), instantiated twice.
REQ-031 Arbitration, message packing and counters stay in the top module; no other hierarchy.

Verification
REQ-032 Single say: meth=5, v=0x1234 at cycle 1, pipe RDY=1 -> cycle 2 ENA=1, v = {0,0,0,0x1234,5,1}; sayCount=1.
REQ-033 Both ENA in cycle 1 (say v=0xA, say2 v=0xB, v2=0xC), RR=1 after reset -> cycle 2 say, cycle 3 say2 with tag 2, v2 field 0xC.
REQ-034 Both slots refilled every cycle, RR=1, 20 cycles -> grants alternate exactly; counters differ by at most 1; RR=0 -> say2Count stays 0.
REQ-035 pipe$enq__RDY low 5 cycles with both slots full -> ENA 0, both RDY 0, data unchanged; RDY high -> transfers resume in round-robin order.
REQ-036 RST pulsed 1 cycle while both slots full -> next cycle ENA 0, both RDY 1, counters 0; no held message ever appears on pipe$enq$v.
REQ-037 CNT_W=4, 17 say transfers -> sayCount = 1 (wrap).

Source files
------------

// File: rtl/echo_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : echo_request_arbiter_pkg
// Brief    : Tag values, message geometry and packing helper shared by the
//            arbiter and anything that decodes its messages.
// Revision : 1.0
// ============================================================================
package echo_request_arbiter_pkg;

    localparam int          FIELD_W       = 32;
    localparam int          MSG_W         = 192;
    localparam logic [31:0] SAY_TAG       = 32'd1;
    localparam logic [31:0] SAY2_TAG      = 32'd2;

    localparam int          TAG_LSB       = 0;
    localparam int          SAY_METH_LSB  = 32;
    localparam int          SAY_V_LSB     = 64;
    localparam int          SAY2_METH_LSB = 96;
    localparam int          SAY2_V_LSB    = 128;
    localparam int          SAY2_V2_LSB   = 160;

    typedef enum logic {
        GRANT_SAY  = 1'b0,
        GRANT_SAY2 = 1'b1
    } grant_e;

    function automatic logic [MSG_W-1:0] pack_msg(
        input logic [FIELD_W-1:0] tag,
        input logic [FIELD_W-1:0] say_meth,
        input logic [FIELD_W-1:0] say_v,
        input logic [FIELD_W-1:0] say2_meth,
        input logic [FIELD_W-1:0] say2_v,
        input logic [FIELD_W-1:0] say2_v2
    );
        logic [MSG_W-1:0] msg;
        msg = '0;
        msg[TAG_LSB       +: FIELD_W] = tag;
        msg[SAY_METH_LSB  +: FIELD_W] = say_meth;
        msg[SAY_V_LSB     +: FIELD_W] = say_v;
        msg[SAY2_METH_LSB +: FIELD_W] = say2_meth;
        msg[SAY2_V_LSB    +: FIELD_W] = say2_v;
        msg[SAY2_V2_LSB   +: FIELD_W] = say2_v2;
        return msg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_hold_slot.sv
`default_nettype none
// ============================================================================
// Module   : echo_hold_slot
// Brief    : One-entry holding register; a load in the same cycle as a clear
//            keeps the slot full with the newly loaded contents.
// Revision : 1.0
// ============================================================================
module echo_hold_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_rdy
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        valid_d = i_load | (valid_q & ~i_clear);
        data_d  = i_load ? i_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    // Reset forces ready so upstream sees an empty slot throughout reset.
    assign o_rdy   = rst | ~valid_q | i_clear;

endmodule
`default_nettype wire

// File: rtl/echo_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : echo_request_arbiter
// Brief    : Merges say/say2 requests into one downstream pipe with
//            round-robin or fixed-priority arbitration and grant counters.
// Revision : 1.0
// ============================================================================
module echo_request_arbiter
    import echo_request_arbiter_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RR    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              request_say__ENA,
    input  logic [31:0]       request_say_meth,
    input  logic [31:0]       request_say_v,
    output logic              request_say__RDY,
    input  logic              request_say2__ENA,
    input  logic [31:0]       request_say2_meth,
    input  logic [31:0]       request_say2_v,
    input  logic [31:0]       request_say2_v2,
    output logic              request_say2__RDY,
    output logic              pipe_enq__ENA,
    output logic [MSG_W-1:0]  pipe_enq_v,
    input  logic              pipe_enq__RDY,
    output logic [CNT_W-1:0]  sayCount,
    output logic [CNT_W-1:0]  say2Count
);

    logic        say_valid;
    logic [63:0] say_data;
    logic        say2_valid;
    logic [95:0] say2_data;
    logic        grant_say;
    logic        grant_say2;
    logic        xfer;
    logic        say_clear;
    logic        say2_clear;

    grant_e           last_q;
    grant_e           last_d;
    logic [CNT_W-1:0] say_cnt_q;
    logic [CNT_W-1:0] say_cnt_d;
    logic [CNT_W-1:0] say2_cnt_q;
    logic [CNT_W-1:0] say2_cnt_d;

    echo_hold_slot #(.WIDTH(64)) u_say_slot (
        .clk     (CLK),
        .rst     (RST),
        .i_load  (request_say__ENA),
        .i_data  ({request_say_v, request_say_meth}),
        .i_clear (say_clear),
        .o_valid (say_valid),
        .o_data  (say_data),
        .o_rdy   (request_say__RDY)
    );

    echo_hold_slot #(.WIDTH(96)) u_say2_slot (
        .clk     (CLK),
        .rst     (RST),
        .i_load  (request_say2__ENA),
        .i_data  ({request_say2_v2, request_say2_v, request_say2_meth}),
        .i_clear (say2_clear),
        .o_valid (say2_valid),
        .o_data  (say2_data),
        .o_rdy   (request_say2__RDY)
    );

    always_comb begin
        // On a tie, round-robin favours whoever was not granted last.
        if (RR != 0) begin
            grant_say = say_valid & (~say2_valid | (last_q == GRANT_SAY2));
        end else begin
            grant_say = say_valid;
        end
        grant_say2 = say2_valid & ~grant_say;
        xfer       = (say_valid | say2_valid) & pipe_enq__RDY & ~RST;
        say_clear  = xfer & grant_say;
        say2_clear = xfer & grant_say2;
    end

    always_comb begin
        last_d     = last_q;
        say_cnt_d  = say_cnt_q;
        say2_cnt_d = say2_cnt_q;
        if (say_clear) begin
            last_d    = GRANT_SAY;
            say_cnt_d = say_cnt_q + CNT_W'(1);
        end
        if (say2_clear) begin
            last_d     = GRANT_SAY2;
            say2_cnt_d = say2_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q     <= GRANT_SAY2;
            say_cnt_q  <= '0;
            say2_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            say_cnt_q  <= say_cnt_d;
            say2_cnt_q <= say2_cnt_d;
        end
    end

    always_comb begin
        pipe_enq_v = '0;
        if (say_clear) begin
            pipe_enq_v = pack_msg(SAY_TAG, say_data[31:0], say_data[63:32],
                                  32'd0, 32'd0, 32'd0);
        end else if (say2_clear) begin
            pipe_enq_v = pack_msg(SAY2_TAG, 32'd0, 32'd0, say2_data[31:0],
                                  say2_data[63:32], say2_data[95:64]);
        end
    end

    assign pipe_enq__ENA = xfer;
    assign sayCount      = say_cnt_q;
    assign say2Count     = say2_cnt_q;

endmodule
`default_nettype wire
